mod_serial_mult: RTL and testbench

- Bit-serial interleaved (Blakley) modular multiplier: computes o_result = (i_a * i_b) mod i_n.
- Responder side of the ECC datapath's single-pulse i_start / o_finished handshake; drop-in service unit for the point-arithmetic controller.
- Operand width selected per operation by i_mode (256/128/64/32-bit fields, encodings from ECCDefine.vh).

---
 rtl/mod_serial_mult.sv | 203 ++++++++++++++++++++
 tb/tb_mod_serial_mult.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_serial_mult.sv
// ---------------------------------------------------------------------------
// mod_serial_mult
//
// Bit-serial interleaved (Blakley) modular multiplier.
// It computes o_result = (i_a * i_b) mod i_n.
//
// The multiplier bits are consumed MSB first, one bit per clock. For each bit
// the accumulator is doubled and reduced. When the bit is set, a is added and
// the sum is reduced again. Each reduction is a single conditional subtract,
// which is enough because acc < n and a < n.
//
// The active operand width W is chosen per operation by i_mode
// (256/128/64/32 bits). Operand bits at or above W are masked off when the
// operands are latched.
//
// Optional feature macro: MODMUL_ZERO_BYPASS_EN
//   When defined, a zero masked a or b skips the RUN phase and completes
//   with latency 1.
//   When undefined, zero operands take the full W+1 cycle path.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_start     single-cycle request pulse, accepted only when idle
//   i_mode      operand width select (BITS256/BITS128/BITS64/BITS32)
//   i_n         modulus, active field must be > 1
//   i_a         multiplicand, active field must be < n
//   i_b         multiplier
//   o_result    product mod n, zero-extended above W
//   o_finished  one-cycle completion pulse
//   o_busy      high from the cycle after start until the finish cycle
// ---------------------------------------------------------------------------

`ifndef MAX_BITS
`define MAX_BITS 256
`endif
`ifndef BITS256
`define BITS256 2'b00
`endif
`ifndef BITS128
`define BITS128 2'b01
`endif
`ifndef BITS64
`define BITS64 2'b10
`endif
`ifndef BITS32
`define BITS32 2'b11
`endif

module mod_serial_mult #(
   parameter int DATA_W = `MAX_BITS,
   parameter int CNT_W  = 9
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [1:0]        i_mode,
   input  logic [DATA_W-1:0] i_n,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_result,
   output logic              o_finished,
   output logic              o_busy
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   n_q, n_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                finished_q, finished_d;

   int unsigned         activeWidth;
   logic [DATA_W-1:0]   activeMask;
   logic [DATA_W-1:0]   aMasked, bMasked, nMasked;

   // Two guard bits keep 2*acc + a representable before the compares.
   logic [DATA_W+1:0]   nExt, aExt;
   logic [DATA_W+1:0]   tDbl, tRed, tAdd;
   logic [DATA_W-1:0]   accNext;

   // Decode the requested width and build the field mask for the operands
   // presented on the inputs this cycle.
   always_comb begin
      activeWidth = 32'd256;
      case (i_mode)
         `BITS256: activeWidth = 32'd256;
         `BITS128: activeWidth = 32'd128;
         `BITS64:  activeWidth = 32'd64;
         `BITS32:  activeWidth = 32'd32;
         default:  activeWidth = 32'd256;
      endcase
      activeMask = '1;
      if (activeWidth < DATA_W) begin
         activeMask = ~({DATA_W{1'b1}} << activeWidth);
      end
      aMasked = i_a & activeMask;
      bMasked = i_b & activeMask;
      nMasked = i_n & activeMask;
   end

   // One Blakley step.
   // The accumulator is doubled and reduced. When the current multiplier bit
   // is set, a is added and the sum is reduced again.
   always_comb begin
      nExt = {2'b00, n_q};
      aExt = {2'b00, a_q};
      tDbl = {1'b0, acc_q, 1'b0};
      tRed = (tDbl >= nExt) ? (tDbl - nExt) : tDbl;
      tAdd = tRed;
      if (b_q[cnt_q]) begin
         tAdd = tRed + aExt;
      end
      accNext = (tAdd >= nExt) ? DATA_W'(tAdd - nExt) : DATA_W'(tAdd);
   end

   // State register and datapath registers.
   // Every register is cleared by the synchronous reset. A reset during a
   // job therefore drops it without a completion pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         n_q        <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         finished_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         a_q        <= a_d;
         b_q        <= b_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         finished_q <= finished_d;
      end
   end

   // Next-state logic.
   // A start is taken only in IDLE and not during the finish cycle. That
   // cycle is already IDLE, so the !finished_q term is what blocks it.
   // The result register is loaded only on the way out of DONE. It therefore
   // holds steady for the whole job.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      a_d        = a_q;
      b_d        = b_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      finished_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start && !finished_q) begin
               a_d     = aMasked;
               b_d     = bMasked;
               n_d     = nMasked;
               acc_d   = '0;
               cnt_d   = CNT_W'(activeWidth - 32'd1);
               state_d = RUN;
`ifdef MODMUL_ZERO_BYPASS_EN
               if ((aMasked == '0) || (bMasked == '0)) begin
                  state_d = DONE;
               end
`endif
            end
         end
         RUN: begin
            acc_d = accNext;
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            result_d   = acc_q;
            finished_d = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign o_result   = result_q;
   assign o_finished = finished_q;
   assign o_busy     = (state_q != IDLE) || finished_q;

endmodule

// File: tb/tb_mod_serial_mult.sv
// ---------------------------------------------------------------------------
// tb_mod_serial_mult
//
// Directed self-checking bench for mod_serial_mult.
// The expected products, latencies and handshake behaviour are all
// hand-computed constants.
// ---------------------------------------------------------------------------

`ifndef BITS256
`define BITS256 2'b00
`endif
`ifndef BITS128
`define BITS128 2'b01
`endif
`ifndef BITS64
`define BITS64 2'b10
`endif
`ifndef BITS32
`define BITS32 2'b11
`endif

module tb_mod_serial_mult;

   logic         clock;
   logic         reset;
   logic         start;
   logic [1:0]   mode;
   logic [255:0] opN, opA, opB;
   logic [255:0] result;
   logic         finished;
   logic         busy;

   int assertCount = 0;
   int failCount   = 0;

`ifdef MODMUL_ZERO_BYPASS_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = 33;
`endif

   mod_serial_mult #(.DATA_W(256), .CNT_W(9)) dut (
      .i_clk      (clock),
      .i_rst      (reset),
      .i_start    (start),
      .i_mode     (mode),
      .i_n        (opN),
      .i_a        (opA),
      .i_b        (opB),
      .o_result   (result),
      .o_finished (finished),
      .o_busy     (busy)
   );

   // Free-running clock with a 10-unit period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point for the bench.
   // It counts every comparison and reports each mismatch.
   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Runs one job. The task is entered and left on a falling edge.
   // - A start pulse is driven immediately and the operands are scrambled
   //   after the start edge.
   // - The task checks latency, the busy length, result hold while busy and
   //   the result value.
   // - extraA/extraB (0 = none) give cycles in which a stray start is pulsed.
   // - The task leaves one cycle after the finish pulse, with single-pulse
   //   and idle already checked.
   task automatic applyStimulus(input string tag, input logic [1:0] m,
                                input logic [255:0] a, input logic [255:0] b,
                                input logic [255:0] n, input logic [255:0] expected,
                                input int expLat, input int extraA, input int extraB);
      int latency;
      int busyCycles;
      logic [255:0] resultBefore;
      latency      = 0;
      busyCycles   = 0;
      resultBefore = result;
      mode  = m;
      opA   = a;
      opB   = b;
      opN   = n;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      opA   = '1;
      opB   = '1;
      opN   = 256'd3;
      mode  = ~m;
      for (int k = 1; k <= expLat + 10; k++) begin
         @(posedge clock);
         #1;
         start = 1'b0;
         @(negedge clock);
         if (busy) busyCycles++;
         if (k == 2) checkOutput({tag, " hold"}, result, resultBefore);
         if (k == extraA || k == extraB) begin
            start = 1'b1;
            opA   = 256'd1;
            opB   = 256'd1;
            opN   = 256'd97;
            mode  = `BITS32;
         end
         if (finished) begin
            latency = k;
            break;
         end
      end
      checkOutput({tag, " latency"}, 256'(latency), 256'(expLat));
      checkOutput({tag, " busy"}, 256'(busyCycles), 256'(expLat));
      checkOutput({tag, " result"}, result, expected);
      @(posedge clock);
      #1;
      start = 1'b0;
      @(negedge clock);
      checkOutput({tag, " pulse"}, 256'(finished), 256'd0);
      checkOutput({tag, " idle"}, 256'(busy), 256'd0);
   endtask

   logic [255:0] n256, n128, n64;
   int seenFinish;

   initial begin
      reset = 1'b1;
      start = 1'b0;
      mode  = `BITS32;
      opA   = '0;
      opB   = '0;
      opN   = '0;
      n256  = {{31{8'hFF}}, 8'h43};
      n128  = {128'd0, {15{8'hFF}}, 8'h61};
      n64   = {192'd0, 64'hFFFFFFFFFFFFFFC5};
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("reset result", result, 256'd0);
      checkOutput("reset finished", 256'(finished), 256'd0);
      checkOutput("reset busy", 256'(busy), 256'd0);

      // 50*60 = 3000 = 30*97 + 90
      applyStimulus("basic", `BITS32, 256'd50, 256'd60, 256'd97, 256'd90, 33, 0, 0);

      // Reset in the middle of a job: no completion, result cleared.
      mode  = `BITS32;
      opA   = 256'd5;
      opB   = 256'd7;
      opN   = 256'd97;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("midreset result", result, 256'd0);
      checkOutput("midreset busy", 256'(busy), 256'd0);
      seenFinish = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (finished) seenFinish++;
      end
      checkOutput("midreset nofinish", 256'(seenFinish), 256'd0);

      // 10*20 = 200 = 2*97 + 6
      applyStimulus("after reset", `BITS32, 256'd10, 256'd20, 256'd97, 256'd6, 33, 0, 0);

      // 12345*67890 = 838102050 = 8380*100003 + 76910
      applyStimulus("mid32", `BITS32, 256'd12345, 256'd67890, 256'd100003, 256'd76910, 33, 0, 0);

      // (-1)*(-1) = 1 mod n
      applyStimulus("max32", `BITS32, 256'hFFFFFFFA, 256'hFFFFFFFA, 256'hFFFFFFFB,
                    256'd1, 33, 0, 0);
      applyStimulus("max256", `BITS256, n256 - 256'd1, n256 - 256'd1, n256,
                    256'd1, 257, 0, 0);

      // 2^127 * 2 = 2^128 = n + 159
      applyStimulus("mode128", `BITS128, 256'd1 << 127, 256'd2, n128, 256'd159, 129, 0, 0);

      // The junk in the upper bits of b and n must be masked away: 2*3 = 6.
      applyStimulus("mask64", `BITS64, 256'd2, {{192{1'b1}}, 64'd3},
                    {{192{1'b1}}, n64[63:0]}, 256'd6, 65, 0, 0);

      // Stray starts at cycle 5 and in the finish cycle are ignored:
      // 5*7 = 35. The next start arrives back to back: 96*96 = (-1)^2 = 1.
      applyStimulus("handshake", `BITS32, 256'd5, 256'd7, 256'd97, 256'd35, 33, 5, 33);
      applyStimulus("back2back", `BITS32, 256'd96, 256'd96, 256'd97, 256'd1, 33, 0, 0);

      applyStimulus("zero a", `BITS32, 256'd0, 256'd123, 256'd97, 256'd0, ZERO_LAT, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Hard watchdog so the run always ends, even if the bench itself stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
